// File: rtl/uart_rx_param.sv
// Parameterised UART receiver: 2-flop input synchronizer, start-bit glitch
// rejection, LSB-first shift, valid/ready output hold with overrun detection.
// Define UART_RX_PARITY_EN to build the parity bit state and checker.
module uart_rx_param #(
    parameter int CLKS_PER_BIT = 870,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_ODD   = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 din,
    output logic [DATA_BITS-1:0] d_out,
    output logic                 d_valid,
    input  logic                 d_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);

    // state     | meaning
    // IDLE      | line high, waiting for a start edge
    // START     | waiting half a bit to re-check the start bit
    // DATA      | sampling DATA_BITS data bits, one per bit time
    // PARITY    | sampling the parity bit (parity build only)
    // STOP      | sampling the stop bit
    // WAIT_IDLE | stop bit was low; waiting for the line to return high

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] BIT_LOAD  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LOAD = CW'((CLKS_PER_BIT - 1) / 2 - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || DATA_BITS < 5 || DATA_BITS > 9 ||
        (PARITY_ODD != 0 && PARITY_ODD != 1)) begin : g_bad_param
        $error("uart_rx_param: parameter out of legal range");
    end

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        WAIT_IDLE
    } state_t;

    state_t               state, state_nxt;
    logic [1:0]           sync_q;
    logic                 din_s;
    logic [CW-1:0]        baud_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_q;
    logic                 baud_tc;
    logic                 par_ok;
    logic                 load_half;
    logic                 load_bit;
    logic                 shift_en;
    logic                 par_sample;
    logic                 stop_good;
    logic                 stop_bad;

    assign din_s   = sync_q[1];
    assign baud_tc = (baud_cnt == '0);

    always_comb begin
        state_nxt  = state;
        load_half  = 1'b0;
        load_bit   = 1'b0;
        shift_en   = 1'b0;
        par_sample = 1'b0;
        stop_good  = 1'b0;
        stop_bad   = 1'b0;
        case (state)
            IDLE: begin
                if (!din_s) begin
                    load_half = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                if (baud_tc) begin
                    if (!din_s) begin
                        load_bit  = 1'b1;
                        state_nxt = DATA;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            DATA: begin
                if (baud_tc) begin
                    shift_en = 1'b1;
                    load_bit = 1'b1;
                    if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                        state_nxt = PARITY;
`else
                        state_nxt = STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
                if (baud_tc) begin
                    par_sample = 1'b1;
                    load_bit   = 1'b1;
                    state_nxt  = STOP;
                end
            end
`endif
            STOP: begin
                if (baud_tc) begin
                    if (din_s) begin
                        stop_good = par_ok;
                        state_nxt = IDLE;
                    end else begin
                        stop_bad  = 1'b1;
                        state_nxt = WAIT_IDLE;
                    end
                end
            end
            WAIT_IDLE: begin
                if (din_s) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sync_q    <= 2'b11;
            baud_cnt  <= '0;
            bit_cnt   <= '0;
            shift_q   <= '0;
            d_out     <= '0;
            d_valid   <= 1'b0;
            frame_err <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            state     <= state_nxt;
            sync_q    <= {sync_q[0], din};
            frame_err <= stop_bad;
            overrun   <= 1'b0;

            // Down-counter reloads at every sample point and parks at zero otherwise.
            if (load_half)
                baud_cnt <= HALF_LOAD;
            else if (load_bit)
                baud_cnt <= BIT_LOAD;
            else if (!baud_tc)
                baud_cnt <= baud_cnt - CW'(1);

            if (load_half)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + BW'(1);

            if (shift_en)
                shift_q <= {din_s, shift_q[DATA_BITS-1:1]};

            // A simultaneous accept frees the holding register for the new word.
            if (stop_good) begin
                if (!d_valid || d_ready) begin
                    d_out   <= shift_q;
                    d_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (d_valid && d_ready) begin
                d_valid <= 1'b0;
            end
        end
    end

`ifdef UART_RX_PARITY_EN
    localparam logic PAR_SENSE = (PARITY_ODD != 0);
    logic par_bad_q;
    logic par_mismatch;

    assign par_mismatch = (din_s != (^shift_q ^ PAR_SENSE));
    assign par_ok       = !par_bad_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            par_bad_q  <= 1'b0;
            parity_err <= 1'b0;
        end else begin
            parity_err <= par_sample && par_mismatch;
            if (load_half)
                par_bad_q <= 1'b0;
            else if (par_sample)
                par_bad_q <= par_mismatch;
        end
    end
`else
    assign par_ok     = 1'b1;
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Randomised and directed bench for uart_rx_param against a frame-level model.
// Honours UART_RX_PARITY_EN to match the DUT build.
module tb_uart_rx_param;

    localparam int CPB  = 20;
    localparam int PODD = 0;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       din = 1'b1;
    logic       d_ready = 1'b1;
    logic [7:0] d_out;
    logic       d_valid, frame_err, parity_err, overrun;

    uart_rx_param #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY_ODD(PODD)) dut (
        .clk(clk), .rst(rst), .din(din), .d_out(d_out), .d_valid(d_valid),
        .d_ready(d_ready), .frame_err(frame_err), .parity_err(parity_err),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // frame-level reference model
    logic [7:0] exp_q[$];
    int         exp_ferr = 0, exp_perr = 0, exp_ovr = 0, exp_loads = 0;
    bit         held = 1'b0;
    logic [7:0] held_word = '0;

    // observed
    logic [7:0] got_q[$];
    int         got_ferr = 0, got_perr = 0, got_ovr = 0, got_rises = 0, stab_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    initial begin
        logic       prev_valid = 1'b0, prev_acc = 1'b0;
        logic [7:0] prev_dout = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (frame_err)  got_ferr++;
                if (parity_err) got_perr++;
                if (overrun)    got_ovr++;
                if (d_valid && !prev_valid) got_rises++;
                if (d_valid && prev_valid && !prev_acc && d_out !== prev_dout) stab_err++;
                if (d_valid && d_ready) got_q.push_back(d_out);
            end
            prev_valid = d_valid && !rst;
            prev_acc   = d_valid && d_ready;
            prev_dout  = d_out;
        end
    end

    task automatic model_frame(input logic [7:0] data, input logic stop, input logic pflip);
        if (PAR_EN && pflip) exp_perr++;
        if (!stop) exp_ferr++;
        if (stop && !(PAR_EN && pflip)) begin
            if (d_ready) begin
                exp_q.push_back(data);
                exp_loads++;
            end else if (held) begin
                exp_ovr++;
            end else begin
                held      = 1'b1;
                held_word = data;
                exp_loads++;
            end
        end
    endtask

    task automatic send_bit(input logic b);
        din = b;
        repeat (CPB) @(posedge clk);
        #1;
    endtask

    task automatic idle(input int bits);
        din = 1'b1;
        repeat (bits * CPB) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] data, input logic stop, input logic pflip);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(data[i]);
        if (PAR_EN) send_bit(^data ^ PODD[0] ^ pflip);
        send_bit(stop);
        model_frame(data, stop, pflip);
        din = 1'b1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic compare_counts(input string tag);
        check({tag, "_ferr"}, got_ferr, exp_ferr);
        check({tag, "_perr"}, got_perr, exp_perr);
        check({tag, "_ovr"},  got_ovr,  exp_ovr);
        check({tag, "_nrx"},  got_q.size(), exp_q.size());
    endtask

    initial begin
        do_reset();
        #3;
        check("rst_dout",   d_out,      0);
        check("rst_valid",  d_valid,    0);
        check("rst_ferr",   frame_err,  0);
        check("rst_perr",   parity_err, 0);
        check("rst_ovr",    overrun,    0);
        @(posedge clk); #1;

        // single frame
        idle(2);
        send_frame(8'h0F, 1'b1, 1'b0);
        idle(2);
        check("s1_dout", d_out, 8'h0F);
        check("s1_rises", got_rises, 1);
        compare_counts("s1");

        // overrun with consumer stalled
        d_ready = 1'b0;
        send_frame(8'h55, 1'b1, 1'b0);
        send_frame(8'hA3, 1'b1, 1'b0);
        idle(2);
        check("s2_dout", d_out, 8'h55);
        check("s2_valid", d_valid, 1);
        compare_counts("s2");
        d_ready = 1'b1;
        if (held) begin
            exp_q.push_back(held_word);
            held = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("s2_valid_clr", d_valid, 0);

        // short glitch on idle line, then a frame one bit time later
        din = 1'b0;
        repeat (CPB / 4) @(posedge clk);
        #1;
        idle(1);
        check("s3_no_valid", got_rises, 2);
        send_frame(8'hC6, 1'b1, 1'b0);
        idle(1);
        check("s3_dout", d_out, 8'hC6);
        compare_counts("s3");

        // framing error then recovery
        send_frame(8'h3C, 1'b0, 1'b0);
        idle(1);
        check("s4_valid", d_valid, 0);
        send_frame(8'h81, 1'b1, 1'b0);
        idle(1);
        check("s4_dout", d_out, 8'h81);
        compare_counts("s4");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h07, 1'b1, 1'b1);
        idle(1);
        check("s5_dout_kept", d_out, 8'h81);
        send_frame(8'h07, 1'b1, 1'b0);
        idle(1);
        check("s5_dout", d_out, 8'h07);
        compare_counts("s5");
`endif

        // reset in the middle of data bit 4 of 0xFF
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        din = 1'b1;
        repeat (CPB / 2) @(posedge clk);
        #1;
        do_reset();
        #3;
        check("s6_rst_dout", d_out, 0);
        @(posedge clk); #1;
        idle(5);
        send_frame(8'h12, 1'b1, 1'b0);
        idle(1);
        check("s6_dout", d_out, 8'h12);
        compare_counts("s6");

        // randomised frames with random gaps, glitches and errors
        for (int n = 0; n < 30; n++) begin
            logic [7:0] data;
            logic       stop, pflip;
            data  = 8'($urandom_range(0, 255));
            stop  = ($urandom_range(0, 7) != 0);
            pflip = PAR_EN && ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 5) == 0) begin
                din = 1'b0;
                repeat ($urandom_range(1, CPB / 4)) @(posedge clk);
                #1;
                idle(1);
            end
            send_frame(data, stop, pflip);
            din = 1'b1;
            repeat (stop ? $urandom_range(0, CPB) : CPB + $urandom_range(0, CPB)) @(posedge clk);
            #1;
        end
        idle(2);
        compare_counts("rnd");
        check("rnd_loads", got_rises, exp_loads);
        check("dout_stable", stab_err, 0);
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            check($sformatf("word%0d", i), got_q[i], exp_q[i]);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
